// File: rtl/mux_rr_stream_if.sv
// =============================================================================
// mux_rr_stream_if : stream bundle for the N:1 registered round-robin mux
// Revision 1.0
// =============================================================================
`default_nettype none

interface mux_rr_stream_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SELW     = $clog2(CHANNELS)
);
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic                      mode;
    logic [SELW-1:0]           sel;
    logic [WIDTH-1:0]          out_data;
    logic [SELW-1:0]           out_chan;
    logic                      out_valid;
    logic                      out_ready;

    // Mux side
    modport slave (
        input  in_data, in_valid, mode, sel, out_ready,
        output in_ready, out_data, out_chan, out_valid
    );

    // Driver/consumer side
    modport master (
        output in_data, in_valid, mode, sel, out_ready,
        input  in_ready, out_data, out_chan, out_valid
    );
endinterface

`default_nettype wire

// File: rtl/mux_rr_stream.sv
// =============================================================================
// mux_rr_stream : registered N:1 valid/ready mux, static select or round-robin
// Revision 1.0
// =============================================================================
`default_nettype none

module mux_rr_stream #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SELW     = $clog2(CHANNELS)
) (
    input  wire              clk,
    input  wire              rst_n,
    mux_rr_stream_if.slave   bus
);

    localparam logic [SELW:0]   C_CHAN_EXT = (SELW+1)'(CHANNELS);
    localparam logic [SELW-1:0] C_LAST     = SELW'(CHANNELS - 1);

    logic [WIDTH-1:0]    r_out_data;
    logic [SELW-1:0]     r_out_chan;
    logic                r_out_valid;
    logic [SELW-1:0]     r_ptr;

    logic                w_can_load;
    logic                w_grant_vld;
    logic [SELW-1:0]     w_grant;
    logic [SELW:0]       w_idx;
    logic                w_xfer_in;
    logic [CHANNELS-1:0] w_in_ready;

    assign w_can_load = !r_out_valid || bus.out_ready;

    always_comb begin
        w_grant_vld = 1'b0;
        w_grant     = '0;
        w_idx       = '0;
        if (!bus.mode) begin
            if (int'(bus.sel) < CHANNELS) begin
                if (bus.in_valid[bus.sel]) begin
                    w_grant_vld = 1'b1;
                    w_grant     = bus.sel;
                end
            end
        end else begin
            // Scan from ptr upward, wrapping modulo CHANNELS; first valid wins.
            for (int i = 0; i < CHANNELS; i++) begin
                w_idx = {1'b0, r_ptr} + (SELW+1)'(i);
                if (w_idx >= C_CHAN_EXT) begin
                    w_idx = w_idx - C_CHAN_EXT;
                end
                if (!w_grant_vld && bus.in_valid[w_idx[SELW-1:0]]) begin
                    w_grant_vld = 1'b1;
                    w_grant     = w_idx[SELW-1:0];
                end
            end
        end
    end

    assign w_xfer_in = rst_n && w_can_load && w_grant_vld;

    always_comb begin
        w_in_ready = '0;
        if (w_xfer_in) begin
            w_in_ready[w_grant] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_chan  <= '0;
            r_out_valid <= 1'b0;
            r_ptr       <= '0;
        end else begin
            if (w_xfer_in) begin
                r_out_data  <= bus.in_data[w_grant*WIDTH +: WIDTH];
                r_out_chan  <= w_grant;
                r_out_valid <= 1'b1;
                if (bus.mode) begin
                    r_ptr <= (w_grant == C_LAST) ? '0 : w_grant + 1'b1;
                end
            end else if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_data  = r_out_data;
    assign bus.out_chan  = r_out_chan;
    assign bus.out_valid = r_out_valid;

endmodule

`default_nettype wire
